// File: rtl/uart_frame_sched.sv
// Groups UART bytes into fixed-length frames and buffers them in a FWFT FIFO with valid/ready output.
// Optional trailing XOR checksum byte per frame when FRAME_CHECKSUM_EN is defined.
module uart_frame_sched #(
    parameter int FRAME_BYTES  = 4,
    parameter int FIFO_DEPTH   = 8,
    parameter int TIMEOUT_CLKS = 2048
) (
    input  logic                          i_Clock,
    input  logic                          i_Reset,
    input  logic                          i_Rx_DV,
    input  logic [7:0]                    i_Rx_Byte,
    output logic [8*FRAME_BYTES-1:0]      o_Frame,
    output logic                          o_Valid,
    input  logic                          i_Ready,
    output logic                          o_Resync,
    output logic                          o_Overflow,
`ifdef FRAME_CHECKSUM_EN
    output logic                          o_Cksum_Err,
`endif
    output logic [$clog2(FIFO_DEPTH):0]   o_Level
);

    localparam int FW       = 8 * FRAME_BYTES;
    localparam int AW       = $clog2(FIFO_DEPTH);
    localparam int TMO_LAST = (TIMEOUT_CLKS > 0) ? TIMEOUT_CLKS - 1 : 0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT
`ifdef FRAME_CHECKSUM_EN
        , S_CHECK
`endif
    } state_e;

    state_e          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [15:0]     tmo_q, tmo_d;
    logic [FW-1:0]   asm_q, asm_d;
    logic [AW:0]     wr_cnt_q, wr_cnt_d;
    logic [AW:0]     rd_cnt_q, rd_cnt_d;
    logic [FW-1:0]   head_q, head_d;
    logic            resync_q, resync_d;
    logic            ovf_q, ovf_d;
    logic [FW-1:0]   mem_q [FIFO_DEPTH];

    logic [FW-1:0]   shifted;
    logic [15:0]     tmo_inc;
    logic            tmo_hit;
    logic            frame_done;
    logic [FW-1:0]   push_data;
    logic [AW:0]     level;
    logic            full;
    logic            pop;
    logic            push;

`ifdef FRAME_CHECKSUM_EN
    logic            cerr_q, cerr_d;
    logic [7:0]      xsum;
`endif

    assign shifted = {asm_q[FW-9:0], i_Rx_Byte};
    assign tmo_inc = tmo_q + 16'd1;
    assign tmo_hit = (TIMEOUT_CLKS != 0) && (int'(tmo_inc) >= TMO_LAST);

    // NOTE: every signal driven here gets a default first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        tmo_d      = tmo_q;
        asm_d      = asm_q;
        resync_d   = 1'b0;
        frame_done = 1'b0;
        push_data  = shifted;
`ifdef FRAME_CHECKSUM_EN
        cerr_d     = 1'b0;
        xsum       = 8'd0;
        for (int i = 0; i < FRAME_BYTES; i++) begin
            xsum = xsum ^ asm_q[8*i +: 8];
        end
`endif
        case (state_q)
            S_IDLE: begin
                if (i_Rx_DV) begin
                    asm_d   = shifted;
                    cnt_d   = 4'd1;
                    tmo_d   = 16'd0;
                    state_d = S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (i_Rx_DV) begin
                    asm_d = shifted;
                    tmo_d = 16'd0;
                    if (cnt_q == 4'(FRAME_BYTES - 1)) begin
                        cnt_d = 4'd0;
`ifdef FRAME_CHECKSUM_EN
                        state_d = S_CHECK;
`else
                        frame_done = 1'b1;
                        state_d    = S_IDLE;
`endif
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end else if (tmo_hit) begin
                    resync_d = 1'b1;
                    cnt_d    = 4'd0;
                    tmo_d    = 16'd0;
                    state_d  = S_IDLE;
                end else begin
                    tmo_d = tmo_inc;
                end
            end
`ifdef FRAME_CHECKSUM_EN
            S_CHECK: begin
                push_data = asm_q;
                if (i_Rx_DV) begin
                    tmo_d   = 16'd0;
                    state_d = S_IDLE;
                    if (i_Rx_Byte == xsum) begin
                        frame_done = 1'b1;
                    end else begin
                        cerr_d = 1'b1;
                    end
                end else if (tmo_hit) begin
                    resync_d = 1'b1;
                    cnt_d    = 4'd0;
                    tmo_d    = 16'd0;
                    state_d  = S_IDLE;
                end else begin
                    tmo_d = tmo_inc;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // A full FIFO still accepts a push when the head is popped on the same edge.
    always_comb begin
        level    = wr_cnt_q - rd_cnt_q;
        full     = (level == (AW+1)'(FIFO_DEPTH));
        pop      = (level != '0) && i_Ready;
        push     = frame_done && (!full || pop);
        ovf_d    = ovf_q || (frame_done && full && !pop);
        wr_cnt_d = wr_cnt_q + {{AW{1'b0}}, push};
        rd_cnt_d = rd_cnt_q + {{AW{1'b0}}, pop};
        head_d   = head_q;
        if (wr_cnt_d != rd_cnt_d) begin
            if (push && (rd_cnt_d[AW-1:0] == wr_cnt_q[AW-1:0])) begin
                head_d = push_data;
            end else begin
                head_d = mem_q[rd_cnt_d[AW-1:0]];
            end
        end
    end

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            tmo_q    <= '0;
            asm_q    <= '0;
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
            head_q   <= '0;
            resync_q <= 1'b0;
            ovf_q    <= 1'b0;
`ifdef FRAME_CHECKSUM_EN
            cerr_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            tmo_q    <= tmo_d;
            asm_q    <= asm_d;
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
            head_q   <= head_d;
            resync_q <= resync_d;
            ovf_q    <= ovf_d;
`ifdef FRAME_CHECKSUM_EN
            cerr_q   <= cerr_d;
`endif
        end
    end

    // NOTE: the frame storage is deliberately not reset; the pointers alone decide which entries are live.
    always_ff @(posedge i_Clock) begin
        if (push) begin
            mem_q[wr_cnt_q[AW-1:0]] <= push_data;
        end
    end

    assign o_Frame    = head_q;
    assign o_Valid    = (wr_cnt_q != rd_cnt_q);
    assign o_Level    = wr_cnt_q - rd_cnt_q;
    assign o_Resync   = resync_q;
    assign o_Overflow = ovf_q;
`ifdef FRAME_CHECKSUM_EN
    assign o_Cksum_Err = cerr_q;
`endif

endmodule

// File: doc/uart_frame_sched.md
Name: uart_frame_sched

Overview:
- Sits between the UART receiver (byte + one-cycle data-valid strobe) and the vector-drawing pipeline.
- Groups received bytes into fixed-length frames, for example point records of x, y and colour bytes.
- Resynchronises on inter-byte timeouts and buffers completed frames in a small FIFO.
- Hands frames to the consumer with a valid/ready handshake, so UART traffic is decoupled from drawing-engine stalls.

Parameters:
- FRAME_BYTES, 4: bytes per frame; legal range 2..8.
- FIFO_DEPTH, 8: frame FIFO depth; must be a power of 2, at least 2.
- TIMEOUT_CLKS, 2048: idle clocks allowed inside a partial frame before it is discarded; 0 disables the timeout. The counter is 16 bits wide.

Ports:
- i_Clock, in, 1: system clock.
- i_Reset, in, 1: synchronous, active-high reset.
- i_Rx_DV, in, 1: one-cycle strobe, received byte valid.
- i_Rx_Byte, in, 8: received byte, sampled only when i_Rx_DV=1.
- o_Frame, out, 8*FRAME_BYTES: head-of-FIFO frame. First byte received is in the MSBs.
- o_Valid, out, 1: FIFO not empty.
- i_Ready, in, 1: consumer accepts the head frame when o_Valid and i_Ready are both 1.
- o_Resync, out, 1: one-cycle pulse when a partial frame is discarded by timeout.
- o_Overflow, out, 1: sticky flag, set when a completed frame is dropped because the FIFO is full. Cleared only by reset.
- o_Level, out, $clog2(FIFO_DEPTH)+1: current FIFO occupancy.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: o_Valid=0, o_Frame=0, o_Resync=0, o_Overflow=0, o_Level=0. Byte counter, timeout counter and FIFO pointers are all 0. State is S_IDLE.
- Reset mid-frame: the partial frame and all FIFO contents are lost. No o_Resync pulse is generated.
- States:
  - S_IDLE: byte count 0. On i_Rx_DV, shift the byte in, set count=1, go to S_COLLECT.
  - S_COLLECT, on i_Rx_DV:
    - Shift the byte in (assembly register shifts left 8 bits; new byte enters the LSBs). Clear the timeout counter.
    - If count==FRAME_BYTES-1, the frame is complete: push it, set count=0, go to S_IDLE.
    - Otherwise increment count.
  - S_COLLECT, no i_Rx_DV: increment the timeout counter.
    - If TIMEOUT_CLKS!=0 and the counter reaches TIMEOUT_CLKS-1: discard the partial frame, pulse o_Resync on the next cycle, set count=0, go to S_IDLE.
  - A DV arriving in the same cycle the timeout expires takes priority: the byte is kept and the timeout is cleared.
- Push:
  - The completed frame is written on the clock edge that samples the last byte's DV.
  - o_Valid rises the following cycle, so latency is 1 clock from the last DV to o_Valid.
  - The FIFO is first-word-fall-through: o_Frame is valid whenever o_Valid=1.
- Pop: on o_Valid and i_Ready, the read pointer advances. The next frame, if any, appears the following cycle.
- Full (o_Level==FIFO_DEPTH):
  - A push coinciding with a pop is accepted and o_Level is unchanged.
  - A push without a pop is dropped and o_Overflow is set. Frame alignment is kept (count still resets).
- Empty: i_Ready is ignored and o_Frame holds its last value.
- Pointer width: pointers are $clog2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH. o_Level = write count minus read count, with one extra bit.
- i_Rx_Byte is ignored when i_Rx_DV=0. Back-to-back DVs on consecutive cycles must be handled, one byte per cycle.

Optional Feature:
- Macro: FRAME_CHECKSUM_EN.
- Defined:
  - Each frame carries one extra trailing byte equal to the XOR of its FRAME_BYTES payload bytes.
  - After the last payload byte, go to S_CHECK and wait for the checksum byte. The timeout rules of S_COLLECT apply in S_CHECK.
  - On match, push the frame on that edge.
  - On mismatch, drop the frame and pulse the extra output o_Cksum_Err (1 bit, reset 0) for one cycle. The FIFO is untouched.
  - Either way, return to S_IDLE.
- Not defined: no S_CHECK state, no o_Cksum_Err port, and behaviour is exactly as above.

Test Plan:
- Defaults; bytes 01,02,03,04 on DV strobes spaced 50 clocks apart, i_Ready=1 → o_Valid=1 for one cycle, starting 1 clock after the 4th DV, with o_Frame=32'h01020304; o_Level returns to 0.
- i_Ready=0; send 3 frames (02040608, 01010101, 0A0B0C0D); then raise i_Ready → o_Level=3, then frames pop in order, one per cycle.
- TIMEOUT_CLKS=16; send bytes AA,BB, wait 20 clocks, then send 01,02,03,04 → o_Resync pulses once; the only frame output is 32'h01020304.
- FIFO_DEPTH=2, i_Ready=0; send 3 frames → o_Level=2, o_Overflow=1, and the 3rd frame is absent after draining.
- Assert i_Reset after 2 bytes of a frame, then send 4 bytes 11,22,33,44 → o_Frame=32'h11223344; no o_Resync pulse.
- With FRAME_CHECKSUM_EN: send 01,02,03,04,04 → frame pushed. Send 01,02,03,04,05 → o_Cksum_Err pulses once and o_Level stays 0.
